// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface fetch_sequencer_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  // Fetch side issues requests and consumes returned data.
  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rdata
  );

  // Memory side answers requests.
  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the F-stage PC and the F->D register, sequences
// instruction fetches over a ready handshake and applies delay-slot redirects from D.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [1:0]             npc_op,
  input  logic                   b_taken,
  input  logic [15:0]            imm16,
  input  logic [25:0]            imm26,
  input  logic [31:0]            ra_addr,
  fetch_sequencer_if.master      im,
  output logic [31:0]            pc_f,
  output logic [31:0]            instr_d,
  output logic [31:0]            pc_d,
  output logic [31:0]            pc8_d,
  output logic                   valid_d
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] nxt_q, nxt_d;
  logic [31:0] hbuf_q, hbuf_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;

  logic        redirect;
  logic [31:0] target;
  logic        advance;
  logic [31:0] adv_data;
  logic        unused_ra_lo;

  // jr targets are word aligned; the low address bits are deliberately dropped.
  assign unused_ra_lo = ^ra_addr[1:0];

  // Decode the D-stage redirect and its target address.
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    case (npc_op)
      2'b01: begin
        redirect = b_taken;
        target   = pc_d_q + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
      end
      2'b10: begin
        redirect = 1'b1;
        target   = {pc_d_q[31:28], imm26, 2'b00};
      end
      2'b11: begin
        redirect = 1'b1;
        target   = {ra_addr[31:2], 2'b00};
      end
      default: begin
        redirect = 1'b0;
        target   = '0;
      end
    endcase
    // A bubble in D or a frozen D cannot redirect.
    redirect = redirect & valid_d_q & ~stall;
  end

  // Next-state: fetch/hold sequencing, F->D transfer and PC selection.
  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    nxt_d     = nxt_q;
    hbuf_d    = hbuf_q;
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    advance   = 1'b0;
    adv_data  = hbuf_q;

    case (state_q)
      StFetch: begin
        if (im.im_ready) begin
          if (stall) begin
            // Data arrived while D is frozen: park it until the stall clears.
            hbuf_d  = im.im_rdata;
            state_d = StHold;
          end else begin
            advance  = 1'b1;
            adv_data = im.im_rdata;
          end
        end else if (!stall) begin
          instr_d_d = '0;
          valid_d_d = 1'b0;
        end
      end
      StHold: begin
        // im_ready here is a protocol violation and is ignored.
        if (!stall) begin
          advance  = 1'b1;
          adv_data = hbuf_q;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    if (advance) begin
      instr_d_d = adv_data;
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b1;
    end

    // The delay slot is the fetch in flight, so a redirect only replaces what follows it.
    if (advance && redirect) begin
      pc_f_d = target;
      nxt_d  = target + 32'd4;
    end else if (advance) begin
      pc_f_d = nxt_q;
      nxt_d  = nxt_q + 32'd4;
    end else if (redirect) begin
      nxt_d = target;
    end
  end

  // State registers with synchronous reset; reset drops any parked data or pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_f_q    <= RESET_PC;
      nxt_q     <= RESET_PC + 32'd4;
      hbuf_q    <= '0;
      instr_d_q <= '0;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      nxt_q     <= nxt_d;
      hbuf_q    <= hbuf_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign im.im_req  = (state_q == StFetch) & ~reset;
  assign im.im_addr = pc_f_q;
  assign pc_f       = pc_f_q;
  assign instr_d    = instr_d_q;
  assign pc_d       = pc_d_q;
  assign pc8_d      = pc_d_q + 32'd8;
  assign valid_d    = valid_d_q;

endmodule
